// File: rtl/card_shoe.sv
// Card shoe: deals 52 cards without repeats, starting each search at an LFSR-chosen index.
// Optional macro CARD_SHOE_FACE_TEN_EN makes J/Q/K read as 10 on `card`.
module card_shoe (
   input  logic       clk,
   input  logic       resetn,
   input  logic       draw_req,
   input  logic       shuffle,
   output logic [3:0] card,
   output logic [1:0] suit,
   output logic       card_valid,
   output logic       busy,
   output logic [5:0] cards_left,
   output logic       deck_empty,
   output logic       reshuffled,
   output logic [1:0] state_dbg
);

   // Handshake: draw_req/shuffle are sampled only while busy is low (IDLE); nothing is
   // queued. Each accepted draw_req yields exactly one card_valid pulse, and card/suit
   // stay stable from that pulse until the next one.

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RESHUFFLE = 2'd1,
      PROBE     = 2'd2,
      DELIVER   = 2'd3
   } state_t;

   state_t      state, next_state;
   logic [51:0] used;
   logic [5:0]  probe_idx;
   logic        pend_draw;
   logic [7:0]  lfsr;
   logic [7:0]  lfsr_nxt;
   logic [5:0]  start_idx;
   logic [5:0]  idx_base;
   logic [1:0]  idx_suit;
   logic [3:0]  rank;
   logic [3:0]  card_val;

   assign lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign start_idx = (lfsr[5:0] >= 6'd52) ? (lfsr[5:0] - 6'd52) : lfsr[5:0];

   // A nonzero seed never reaches zero; the reload only guards against upsets.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         lfsr <= 8'hA5;
      else
         lfsr <= (lfsr_nxt == 8'h00) ? 8'h01 : lfsr_nxt;
   end

   always_comb begin
      idx_suit = 2'd0;
      idx_base = 6'd0;
      if (probe_idx >= 6'd39) begin
         idx_suit = 2'd3;
         idx_base = 6'd39;
      end else if (probe_idx >= 6'd26) begin
         idx_suit = 2'd2;
         idx_base = 6'd26;
      end else if (probe_idx >= 6'd13) begin
         idx_suit = 2'd1;
         idx_base = 6'd13;
      end
      rank = 4'(probe_idx - idx_base) + 4'd1;
`ifdef CARD_SHOE_FACE_TEN_EN
      card_val = (rank > 4'd10) ? 4'd10 : rank;
`else
      card_val = rank;
`endif
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (shuffle)
               next_state = RESHUFFLE;
            else if (draw_req)
               next_state = (cards_left == 6'd0) ? RESHUFFLE : PROBE;
         end
         RESHUFFLE: next_state = pend_draw ? PROBE : IDLE;
         PROBE:     next_state = used[probe_idx] ? PROBE : DELIVER;
         DELIVER:   next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy       = (state != IDLE);
      card_valid = (state == DELIVER);
      reshuffled = (state == RESHUFFLE);
      state_dbg  = state;
   end

   assign deck_empty = (cards_left == 6'd0);

   // Deck datapath: bitmap, count, probe pointer and the delivered card register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         used       <= '0;
         cards_left <= 6'd52;
         probe_idx  <= 6'd0;
         pend_draw  <= 1'b0;
         card       <= 4'd0;
         suit       <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (!shuffle && draw_req) begin
                  if (cards_left == 6'd0)
                     pend_draw <= 1'b1;
                  else
                     probe_idx <= start_idx;
               end
            end
            RESHUFFLE: begin
               used       <= '0;
               cards_left <= 6'd52;
               if (pend_draw) begin
                  probe_idx <= start_idx;
                  pend_draw <= 1'b0;
               end
            end
            PROBE: begin
               if (used[probe_idx]) begin
                  probe_idx <= (probe_idx == 6'd51) ? 6'd0 : (probe_idx + 6'd1);
               end else begin
                  used[probe_idx] <= 1'b1;
                  cards_left      <= cards_left - 6'd1;
                  card            <= card_val;
                  suit            <= idx_suit;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: randomized draw spacing checked against a
// deck model that predicts each card and its latency from the LFSR and a used-card set.
module tb_card_shoe;

   localparam int W = 14;

   logic       clk;
   logic       resetn;
   logic       draw_req;
   logic       shuffle;
   logic [3:0] card;
   logic [1:0] suit;
   logic       card_valid;
   logic       busy;
   logic [5:0] cards_left;
   logic       deck_empty;
   logic       reshuffled;
   logic [1:0] state_dbg;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [7:0]  m_lfsr;
   bit   [51:0] m_used;
   int          m_left;
   logic [W-1:0] exp_q[$];

   card_shoe dut (
      .clk        (clk),
      .resetn     (resetn),
      .draw_req   (draw_req),
      .shuffle    (shuffle),
      .card       (card),
      .suit       (suit),
      .card_valid (card_valid),
      .busy       (busy),
      .cards_left (cards_left),
      .deck_empty (deck_empty),
      .reshuffled (reshuffled),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) m_lfsr <= 8'hA5;
      else         m_lfsr <= lfsr_step(m_lfsr);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish before limit");
      $fatal(1);
   end

   // ---------------- model ----------------
   function automatic int start_of(input logic [7:0] l);
      int v;
      v = int'(l[5:0]);
      return (v >= 52) ? v - 52 : v;
   endfunction

   function automatic logic [3:0] exp_card(input int idx);
      int r;
      r = idx % 13 + 1;
`ifdef CARD_SHOE_FACE_TEN_EN
      if (r > 10) r = 10;
`endif
      return 4'(r);
   endfunction

   function automatic logic [1:0] exp_suit(input int idx);
      return 2'(idx / 13);
   endfunction

   // Predict the card dealt for a draw sampled while the LFSR holds l, and commit it.
   task automatic predict(input logic [7:0] l, output int idx, output int lat, output bit resh);
      resh = (m_left == 0);
      if (resh) begin
         m_used = '0;
         m_left = 52;
         l = lfsr_step(l);
      end
      idx = start_of(l);
      lat = 2 + int'(resh);
      while (m_used[idx]) begin
         idx = (idx == 51) ? 0 : idx + 1;
         lat++;
      end
      m_used[idx] = 1'b1;
      m_left--;
   endtask

   task automatic model_reset();
      m_used = '0;
      m_left = 52;
   endtask

   // ---------------- driver ----------------
   task automatic draw_one(output logic [7:0] snap, output int lat, output bit saw_resh,
                           output bit timed_out);
      @(negedge clk);
      snap      = m_lfsr;
      draw_req  = 1'b1;
      lat       = 0;
      saw_resh  = 1'b0;
      timed_out = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         draw_req = 1'b0;
         lat++;
         if (reshuffled) saw_resh = 1'b1;
         if (card_valid) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic idle_gap();
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetn   = 1'b0;
      draw_req = 1'b0;
      shuffle  = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({card, suit, card_valid, busy, cards_left, deck_empty, reshuffled, state_dbg} !==
          {4'd0, 2'd0, 1'b0, 1'b0, 6'd52, 1'b0, 1'b0, 2'd0})
         $display("FAIL reset_hold: card=%0d suit=%0d v=%b busy=%b left=%0d empty=%b resh=%b st=%0d, required 0/0/0/0/52/0/0/0",
                  card, suit, card_valid, busy, cards_left, deck_empty, reshuffled, state_dbg);
      else n_pass++;
      resetn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({card_valid, busy, cards_left, deck_empty, reshuffled} !== {1'b0, 1'b0, 6'd52, 1'b0, 1'b0})
         $display("FAIL reset_release: v=%b busy=%b left=%0d empty=%b resh=%b, required 0/0/52/0/0",
                  card_valid, busy, cards_left, deck_empty, reshuffled);
      else n_pass++;
   endtask

   task automatic test_full_deck();
      logic [7:0] snap;
      int lat, elat, idx, tens, maxc;
      bit rs, ers, to;
      bit [51:0] seen;
      seen = '0;
      tens = 0;
      maxc = 0;
      for (int n = 0; n < 52; n++) begin
         idle_gap();
         draw_one(snap, lat, rs, to);
         predict(snap, idx, elat, ers);
         n_checks++;
         if (to) begin
            $display("FAIL deck_timeout: draw %0d got no card_valid, required one within 60 cycles", n);
            continue;
         end else n_pass++;
         if (card == 4'd10) tens++;
         if (int'(card) > maxc) maxc = int'(card);
         n_checks++;
         if ({card, suit} !== {exp_card(idx), exp_suit(idx)})
            $display("FAIL deck_card: draw %0d card=%0d suit=%0d, required card=%0d suit=%0d",
                     n, card, suit, exp_card(idx), exp_suit(idx));
         else n_pass++;
         n_checks++;
         if (lat !== elat || rs !== ers)
            $display("FAIL deck_latency: draw %0d latency=%0d resh=%b, required %0d resh=%b", n, lat, rs, elat, ers);
         else n_pass++;
         n_checks++;
         if (int'(cards_left) !== 51 - n)
            $display("FAIL deck_count: draw %0d cards_left=%0d, required %0d", n, cards_left, 51 - n);
         else n_pass++;
`ifndef CARD_SHOE_FACE_TEN_EN
         n_checks++;
         if (card >= 4'd1 && card <= 4'd13 && !seen[int'(suit) * 13 + int'(card) - 1]) begin
            seen[int'(suit) * 13 + int'(card) - 1] = 1'b1;
            n_pass++;
         end else
            $display("FAIL deck_distinct: draw %0d card=%0d suit=%0d, required an undealt card", n, card, suit);
`endif
      end
      n_checks++;
      if (deck_empty !== 1'b1 || cards_left !== 6'd0)
         $display("FAIL deck_empty: deck_empty=%b cards_left=%0d, required 1 and 0", deck_empty, cards_left);
      else n_pass++;
`ifdef CARD_SHOE_FACE_TEN_EN
      n_checks++;
      if (tens !== 16 || maxc > 10)
         $display("FAIL face_ten: tens=%0d max=%0d, required 16 and <=10", tens, maxc);
      else n_pass++;
`else
      n_checks++;
      if (tens !== 4 || maxc !== 13)
         $display("FAIL rank_range: tens=%0d max=%0d, required 4 and 13", tens, maxc);
      else n_pass++;
`endif
   endtask

   task automatic test_auto_reshuffle();
      logic [7:0] snap;
      int lat, elat, idx;
      bit rs, ers, to;
      draw_one(snap, lat, rs, to);
      predict(snap, idx, elat, ers);
      n_checks++;
      if (to || rs !== 1'b1 || lat !== elat)
         $display("FAIL auto_reshuffle: timeout=%b resh=%b latency=%0d, required 0/1/%0d", to, rs, lat, elat);
      else n_pass++;
      n_checks++;
      if ({card, suit, cards_left} !== {exp_card(idx), exp_suit(idx), 6'd51})
         $display("FAIL auto_card: card=%0d suit=%0d left=%0d, required %0d/%0d/51",
                  card, suit, cards_left, exp_card(idx), exp_suit(idx));
      else n_pass++;
   endtask

   task automatic test_shuffle();
      logic [7:0] snap;
      int lat, elat, idx;
      bit rs, ers, to;
      for (int n = 0; n < 10; n++) begin
         idle_gap();
         draw_one(snap, lat, rs, to);
         predict(snap, idx, elat, ers);
         n_checks++;
         if (to || lat !== elat || {card, suit} !== {exp_card(idx), exp_suit(idx)})
            $display("FAIL pre_shuffle_draw: draw %0d card=%0d suit=%0d lat=%0d, required %0d/%0d/%0d",
                     n, card, suit, lat, exp_card(idx), exp_suit(idx), elat);
         else n_pass++;
      end
      @(negedge clk);
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      n_checks++;
      if (reshuffled !== 1'b1 || busy !== 1'b1)
         $display("FAIL shuffle_pulse: reshuffled=%b busy=%b, required 1/1", reshuffled, busy);
      else n_pass++;
      model_reset();
      @(negedge clk);
      n_checks++;
      if (cards_left !== 6'd52 || reshuffled !== 1'b0 || busy !== 1'b0)
         $display("FAIL shuffle_done: left=%0d resh=%b busy=%b, required 52/0/0", cards_left, reshuffled, busy);
      else n_pass++;
      draw_one(snap, lat, rs, to);
      predict(snap, idx, elat, ers);
      n_checks++;
      if (to || lat !== 2 || {card, suit} !== {exp_card(idx), exp_suit(idx)})
         $display("FAIL post_shuffle_draw: lat=%0d card=%0d suit=%0d, required 2/%0d/%0d",
                  lat, card, suit, exp_card(idx), exp_suit(idx));
      else n_pass++;
   endtask

   task automatic test_held_draw();
      logic [7:0] l;
      logic [W-1:0] e;
      int t, idx, lat, cyc, last;
      bit r;
      idle_gap();
      @(negedge clk);
      l        = m_lfsr;
      draw_req = 1'b1;
      exp_q.delete();
      t = 0;
      while (t <= 19) begin
         predict(l, idx, lat, r);
         exp_q.push_back({8'(t + lat), exp_suit(idx), exp_card(idx)});
         repeat (lat + 1) l = lfsr_step(l);
         t += lat + 1;
      end
      cyc  = 0;
      last = -10;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         cyc++;
         if (cyc == 20) draw_req = 1'b0;
         if (card_valid) begin
            n_checks++;
            if (exp_q.size() == 0)
               $display("FAIL held_extra: pulse at cycle %0d card=%0d, required no pulse", cyc, card);
            else begin
               e = exp_q.pop_front();
               if ({8'(cyc), suit, card} !== e)
                  $display("FAIL held_pulse: cycle=%0d suit=%0d card=%0d, required cycle=%0d suit=%0d card=%0d",
                           cyc, suit, card, e[13:6], e[5:4], e[3:0]);
               else n_pass++;
            end
            n_checks++;
            if (cyc - last < 3)
               $display("FAIL held_gap: pulse gap %0d cycles, required >= 3", cyc - last);
            else n_pass++;
            last = cyc;
         end
         if (cyc >= 20 && exp_q.size() == 0 && !busy) break;
      end
      draw_req = 1'b0;
      n_checks++;
      if (exp_q.size() != 0 || int'(cards_left) !== m_left)
         $display("FAIL held_end: missing=%0d cards_left=%0d, required 0 and %0d", exp_q.size(), cards_left, m_left);
      else n_pass++;
   endtask

   task automatic test_shuffle_while_busy();
      logic [7:0] snap;
      int lat, elat, idx;
      bit ers, saw, to, busy_seen;
      idle_gap();
      @(negedge clk);
      snap      = m_lfsr;
      draw_req  = 1'b1;
      lat       = 0;
      saw       = 1'b0;
      to        = 1'b1;
      busy_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            draw_req  = 1'b0;
            shuffle   = 1'b1;
            busy_seen = busy;
         end else shuffle = 1'b0;
         if (reshuffled) saw = 1'b1;
         if (card_valid) begin
            to = 1'b0;
            break;
         end
      end
      shuffle = 1'b0;
      predict(snap, idx, elat, ers);
      n_checks++;
      if (to || !busy_seen || saw || lat !== elat || {card, suit} !== {exp_card(idx), exp_suit(idx)})
         $display("FAIL busy_shuffle: to=%b busy=%b resh=%b lat=%0d card=%0d suit=%0d, required 0/1/0/%0d/%0d/%0d",
                  to, busy_seen, saw, lat, card, suit, elat, exp_card(idx), exp_suit(idx));
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (reshuffled !== 1'b0 || int'(cards_left) !== m_left)
         $display("FAIL busy_shuffle_after: resh=%b left=%0d, required 0/%0d", reshuffled, cards_left, m_left);
      else n_pass++;
   endtask

   task automatic test_reset_mid_probe();
      bit sawv;
      idle_gap();
      @(negedge clk);
      draw_req = 1'b1;
      @(negedge clk);
      draw_req = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || state_dbg !== 2'd2)
         $display("FAIL probe_entry: busy=%b state=%0d, required 1/2", busy, state_dbg);
      else n_pass++;
      resetn = 1'b0;
      model_reset();
      sawv = 1'b0;
      repeat (3) begin
         @(negedge clk);
         sawv |= card_valid;
      end
      n_checks++;
      if (cards_left !== 6'd52 || busy !== 1'b0 || card !== 4'd0 || suit !== 2'd0)
         $display("FAIL probe_reset_vals: left=%0d busy=%b card=%0d suit=%0d, required 52/0/0/0",
                  cards_left, busy, card, suit);
      else n_pass++;
      resetn = 1'b1;
      repeat (5) begin
         @(negedge clk);
         sawv |= card_valid;
      end
      n_checks++;
      if (sawv !== 1'b0 || cards_left !== 6'd52)
         $display("FAIL probe_abort: card_valid seen=%b left=%0d, required 0/52", sawv, cards_left);
      else n_pass++;
   endtask

   task automatic test_reset_mid_reshuffle();
      logic [7:0] snap;
      int lat, elat, idx;
      bit rs, ers, to;
      @(negedge clk);
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      n_checks++;
      if (reshuffled !== 1'b1)
         $display("FAIL resh_entry: reshuffled=%b, required 1", reshuffled);
      else n_pass++;
      resetn = 1'b0;
      model_reset();
      @(negedge clk);
      n_checks++;
      if ({reshuffled, busy, card_valid, cards_left} !== {1'b0, 1'b0, 1'b0, 6'd52})
         $display("FAIL resh_reset: resh=%b busy=%b v=%b left=%0d, required 0/0/0/52",
                  reshuffled, busy, card_valid, cards_left);
      else n_pass++;
      resetn = 1'b1;
      idle_gap();
      draw_one(snap, lat, rs, to);
      predict(snap, idx, elat, ers);
      n_checks++;
      if (to || lat !== elat || {card, suit} !== {exp_card(idx), exp_suit(idx)} || cards_left !== 6'd51)
         $display("FAIL after_reset_draw: lat=%0d card=%0d suit=%0d left=%0d, required %0d/%0d/%0d/51",
                  lat, card, suit, cards_left, elat, exp_card(idx), exp_suit(idx));
      else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_full_deck();
      test_auto_reshuffle();
      test_shuffle();
      test_held_draw();
      test_shuffle_while_busy();
      test_reset_mid_probe();
      test_reset_mid_reshuffle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
